tex_req_sequencer: RTL and testbench

- Slave-side front-end of the texture bus. Accepts one multi-lane texture request (mask, u/v coords, lod, stage, tag) from a core's texture agent.
- Serialises the active lanes one at a time into a single-lane sampler pipeline, then collects the per-lane texels in issue order.
- Returns one response carrying all NUM_LANES texels plus the unmodified request tag.
- Sits between the texture bus arbiter and the sampler datapath inside the texture unit.

---
 rtl/tex_req_sequencer_if.sv | 65 ++++++
 rtl/tex_req_sequencer.sv | 170 +++++++++++++++++
 tb/tb_tex_req_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tex_req_sequencer_if.sv
// -----------------------------------------------------------------------------
// tex_req_sequencer_if
// Texture bus bundle between a core's texture agent, the request sequencer and
// the single-lane sampler pipeline.
//   request  : req_valid/req_ready, req_mask, req_coords (u lanes low, v lanes
//              high), req_lod, req_stage, req_tag
//   issue    : smp_valid/smp_ready, smp_u, smp_v, smp_lod, smp_stage
//   texel    : smp_rsp_valid/smp_rsp_ready, smp_rsp_texel
//   response : rsp_valid/rsp_ready, rsp_texels, rsp_tag
// Modports:
//   slave  - the sequencer's view
//   master - the surrounding agent/sampler view
// -----------------------------------------------------------------------------
interface tex_req_sequencer_if #(
    parameter int NUM_LANES  = 4,
    parameter int LOD_BITS   = 4,
    parameter int STAGE_BITS = 1,
    parameter int TAG_WIDTH  = 16
);
    logic                          req_valid;
    logic                          req_ready;
    logic [NUM_LANES-1:0]          req_mask;
    logic [2*NUM_LANES*32-1:0]     req_coords;
    logic [NUM_LANES*LOD_BITS-1:0] req_lod;
    logic [STAGE_BITS-1:0]         req_stage;
    logic [TAG_WIDTH-1:0]          req_tag;

    logic                          smp_valid;
    logic                          smp_ready;
    logic [31:0]                   smp_u;
    logic [31:0]                   smp_v;
    logic [LOD_BITS-1:0]           smp_lod;
    logic [STAGE_BITS-1:0]         smp_stage;

    logic                          smp_rsp_valid;
    logic                          smp_rsp_ready;
    logic [31:0]                   smp_rsp_texel;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [NUM_LANES*32-1:0]       rsp_texels;
    logic [TAG_WIDTH-1:0]          rsp_tag;

    modport slave (
        input  req_valid, req_mask, req_coords, req_lod, req_stage, req_tag,
        output req_ready,
        output smp_valid, smp_u, smp_v, smp_lod, smp_stage,
        input  smp_ready,
        input  smp_rsp_valid, smp_rsp_texel,
        output smp_rsp_ready,
        output rsp_valid, rsp_texels, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_mask, req_coords, req_lod, req_stage, req_tag,
        input  req_ready,
        input  smp_valid, smp_u, smp_v, smp_lod, smp_stage,
        output smp_ready,
        output smp_rsp_valid, smp_rsp_texel,
        input  smp_rsp_ready,
        input  rsp_valid, rsp_texels, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/tex_req_sequencer.sv
// -----------------------------------------------------------------------------
// tex_req_sequencer
// Accepts one multi-lane texture request, issues its active lanes one at a
// time (lowest lane first) to a single-lane sampler, gathers the texels that
// come back in issue order and returns them in one response with the original
// tag.
// Ports:
//   clk      - clock
//   reset    - asynchronous active-high reset
//   tex_bus  - tex_req_sequencer_if.slave (request, issue, texel, response)
//   perf_reqs / perf_lanes / perf_stalls - 32-bit event counters, present only
//              when TEX_REQ_SEQUENCER_PERF_EN is defined
// Build option: TEX_REQ_SEQUENCER_PERF_EN
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for a request (req_ready high once out of reset)
// BUSY  | issuing lanes to the sampler and collecting texels
// RESP  | response presented, held until rsp_ready
// -----------------------------------------------------------------------------
module tex_req_sequencer #(
    parameter int NUM_LANES  = 4,
    parameter int LOD_BITS   = 4,
    parameter int STAGE_BITS = 1,
    parameter int TAG_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    tex_req_sequencer_if.slave tex_bus
`ifdef TEX_REQ_SEQUENCER_PERF_EN
    ,
    output logic [31:0]        perf_reqs,
    output logic [31:0]        perf_lanes,
    output logic [31:0]        perf_stalls
`endif
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                             r_state;
    logic                               r_req_ready;
    logic [NUM_LANES-1:0]               r_issue_mask;
    logic [NUM_LANES-1:0]               r_ret_mask;
    logic [NUM_LANES-1:0][31:0]         r_u;
    logic [NUM_LANES-1:0][31:0]         r_v;
    logic [NUM_LANES-1:0][LOD_BITS-1:0] r_lod;
    logic [STAGE_BITS-1:0]              r_stage;
    logic [TAG_WIDTH-1:0]               r_tag;
    logic [NUM_LANES-1:0][31:0]         r_texels;

    logic [IDX_W-1:0]                   w_issue_idx;
    logic [IDX_W-1:0]                   w_ret_idx;
    logic                               w_req_fire;
    logic                               w_smp_valid;
    logic                               w_issue_fire;
    logic                               w_outstanding;
    logic                               w_ret_fire;
    logic [NUM_LANES-1:0]               w_ret_mask_nxt;

    // Lowest set bit of each mask; scanning downward lets the lowest win.
    always_comb begin
        w_issue_idx = '0;
        w_ret_idx   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (r_issue_mask[i]) w_issue_idx = IDX_W'(i);
            if (r_ret_mask[i])   w_ret_idx   = IDX_W'(i);
        end
    end

    assign w_req_fire    = tex_bus.req_valid && r_req_ready;
    assign w_smp_valid   = (r_state == BUSY) && (|r_issue_mask);
    assign w_issue_fire  = w_smp_valid && tex_bus.smp_ready;
    // Both masks drain lowest-first, so any difference means a lane is in the sampler.
    assign w_outstanding = (r_ret_mask != r_issue_mask);
    assign w_ret_fire    = (r_state == BUSY) && tex_bus.smp_rsp_valid && w_outstanding;
    assign w_ret_mask_nxt = w_ret_fire ? (r_ret_mask & (r_ret_mask - NUM_LANES'(1))) : r_ret_mask;

    assign tex_bus.req_ready     = r_req_ready;
    assign tex_bus.smp_valid     = w_smp_valid;
    assign tex_bus.smp_u         = r_u[w_issue_idx];
    assign tex_bus.smp_v         = r_v[w_issue_idx];
    assign tex_bus.smp_lod       = r_lod[w_issue_idx];
    assign tex_bus.smp_stage     = r_stage;
    assign tex_bus.smp_rsp_ready = (r_state == BUSY);
    assign tex_bus.rsp_valid     = (r_state == RESP);
    assign tex_bus.rsp_texels    = r_texels;
    assign tex_bus.rsp_tag       = r_tag;

    // req_ready is a register so it reads 0 while reset is held; it rises on
    // the first clock after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_issue_mask <= '0;
            r_ret_mask   <= '0;
            r_u          <= '0;
            r_v          <= '0;
            r_lod        <= '0;
            r_stage      <= '0;
            r_tag        <= '0;
            r_texels     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_req_fire) begin
                        r_req_ready  <= 1'b0;
                        r_u          <= tex_bus.req_coords[NUM_LANES*32-1:0];
                        r_v          <= tex_bus.req_coords[2*NUM_LANES*32-1:NUM_LANES*32];
                        r_lod        <= tex_bus.req_lod;
                        r_stage      <= tex_bus.req_stage;
                        r_tag        <= tex_bus.req_tag;
                        r_issue_mask <= tex_bus.req_mask;
                        r_ret_mask   <= tex_bus.req_mask;
                        r_texels     <= '0;
                        r_state      <= (|tex_bus.req_mask) ? BUSY : RESP;
                    end
                end
                BUSY: begin
                    if (w_issue_fire)
                        r_issue_mask <= r_issue_mask & (r_issue_mask - NUM_LANES'(1));
                    if (w_ret_fire)
                        r_texels[w_ret_idx] <= tex_bus.smp_rsp_texel;
                    r_ret_mask <= w_ret_mask_nxt;
                    if (w_ret_mask_nxt == '0)
                        r_state <= RESP;
                end
                RESP: begin
                    if (tex_bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A texel with nothing in flight means the sampler broke its contract;
    // the texel is dropped by the w_outstanding gate above.
    a_no_orphan_texel: assert property (
        @(posedge clk) disable iff (reset)
        ((r_state == BUSY) && tex_bus.smp_rsp_valid) |-> w_outstanding
    ) else $error("sampler texel returned with no lane outstanding");

`ifdef TEX_REQ_SEQUENCER_PERF_EN
    logic [31:0] r_perf_reqs;
    logic [31:0] r_perf_lanes;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_reqs   <= '0;
            r_perf_lanes  <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_req_fire)                        r_perf_reqs   <= r_perf_reqs + 32'd1;
            if (w_issue_fire)                      r_perf_lanes  <= r_perf_lanes + 32'd1;
            if (w_smp_valid && !tex_bus.smp_ready) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_reqs   = r_perf_reqs;
    assign perf_lanes  = r_perf_lanes;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_tex_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tex_req_sequencer
// Directed bench for tex_req_sequencer with a behavioural sampler (texel =
// u + v, two cycles after issue) and scoreboards for issue order and responses.
// Inputs change on the falling edge; the monitor samples 4 time units later,
// just ahead of the rising edge, so it sees exactly what the DUT will sample.
// Perf counter checks are compiled in with TEX_REQ_SEQUENCER_PERF_EN.
// -----------------------------------------------------------------------------
module tb_tex_req_sequencer;

    localparam int NL  = 4;
    localparam int LB  = 4;
    localparam int SB  = 1;
    localparam int TW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tex_req_sequencer_if #(.NUM_LANES(NL), .LOD_BITS(LB), .STAGE_BITS(SB), .TAG_WIDTH(TW)) bus ();

`ifdef TEX_REQ_SEQUENCER_PERF_EN
    logic [31:0] perf_reqs;
    logic [31:0] perf_lanes;
    logic [31:0] perf_stalls;
`endif

    tex_req_sequencer #(.NUM_LANES(NL), .LOD_BITS(LB), .STAGE_BITS(SB), .TAG_WIDTH(TW)) dut (
        .clk     (clk),
        .reset   (reset),
        .tex_bus (bus)
`ifdef TEX_REQ_SEQUENCER_PERF_EN
        ,
        .perf_reqs   (perf_reqs),
        .perf_lanes  (perf_lanes),
        .perf_stalls (perf_stalls)
`endif
    );

    typedef struct {
        logic [31:0]   u;
        logic [31:0]   v;
        logic [LB-1:0] lod;
        logic [SB-1:0] stage;
    } iss_t;

    typedef struct {
        logic [NL*32-1:0] texels;
        logic [TW-1:0]    tag;
    } rsp_t;

    typedef struct {
        logic [31:0] texel;
        int          due;
    } pipe_t;

    iss_t  exp_iss[$];
    rsp_t  exp_rsp[$];
    pipe_t pipe[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_issue  = 0;
    int n_stall  = 0;
    int n_req    = 0;
    int n_rsp    = 0;
    int n_rv     = 0;
    int n_sv     = 0;
    bit ready_mode = 1'b0;
    bit in_flight  = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampler model and monitor.
    initial begin
        rsp_t r;
        iss_t e;
        bus.smp_rsp_valid = 1'b0;
        bus.smp_rsp_texel = '0;
        forever begin
            @(negedge clk);
            if (ready_mode) bus.smp_ready = ~bus.smp_ready;
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                bus.smp_rsp_valid = 1'b1;
                bus.smp_rsp_texel = pipe[0].texel;
            end else begin
                bus.smp_rsp_valid = 1'b0;
                bus.smp_rsp_texel = '0;
            end
            #4;
            if (!reset) begin
                if (in_flight) check("req_ready_while_busy", bus.req_ready, 1'b0);
                if (bus.req_valid && bus.req_ready) n_req++;
                if (bus.smp_rsp_valid && bus.smp_rsp_ready && pipe.size() > 0) void'(pipe.pop_front());
                if (bus.smp_valid) begin
                    n_sv++;
                    if (exp_iss.size() == 0) begin
                        check("issue_unexpected", bus.smp_valid, 1'b0);
                    end else begin
                        e = exp_iss[0];
                        check("issue_u", bus.smp_u, e.u);
                        check("issue_v", bus.smp_v, e.v);
                        check("issue_lod", bus.smp_lod, e.lod);
                        check("issue_stage", bus.smp_stage, e.stage);
                        if (bus.smp_ready) begin
                            void'(exp_iss.pop_front());
                            n_issue++;
                            pipe.push_back('{texel: bus.smp_u + bus.smp_v, due: cyc + LAT});
                        end else begin
                            n_stall++;
                        end
                    end
                end
                if (bus.rsp_valid) n_rv++;
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", bus.rsp_valid, 1'b0);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_texels", bus.rsp_texels, r.texels);
                        check("rsp_tag", bus.rsp_tag, r.tag);
                    end
                    n_rsp++;
                    in_flight = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Drives one request, records its expected issues and response, and
    // returns on the falling edge right after it is accepted.
    task automatic send_req(input logic [NL-1:0] mask, input logic [TW-1:0] tag,
                            input logic [31:0] ubase, input logic [31:0] vbase,
                            input logic [SB-1:0] stage);
        logic [2*NL*32-1:0] coords;
        logic [NL*LB-1:0]   lods;
        logic [NL*32-1:0]   tex;
        logic [31:0]        u;
        logic [31:0]        v;
        int                 waited;
        coords = '0;
        lods   = '0;
        tex    = '0;
        waited = 0;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            u = ubase + 32'(l) * 32'h10;
            v = vbase + 32'(l) * 32'h20;
            coords[l*32 +: 32]      = u;
            coords[(NL+l)*32 +: 32] = v;
            lods[l*LB +: LB]        = LB'(l * 3 + 1);
            if (mask[l]) begin
                exp_iss.push_back('{u: u, v: v, lod: LB'(l * 3 + 1), stage: stage});
                tex[l*32 +: 32] = u + v;
            end
        end
        exp_rsp.push_back('{texels: tex, tag: tag});
        bus.req_valid  = 1'b1;
        bus.req_mask   = mask;
        bus.req_coords = coords;
        bus.req_lod    = lods;
        bus.req_stage  = stage;
        bus.req_tag    = tag;
        #4;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            #4;
            waited++;
        end
        check("req_accept", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        in_flight     = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int w;
        w = 0;
        while (n_rsp < target && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(tag, n_rsp, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv0;
        int sv0;
        int st0;
        int is0;
        int w;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_mask   = '0;
        bus.req_coords = '0;
        bus.req_lod    = '0;
        bus.req_stage  = '0;
        bus.req_tag    = '0;
        bus.smp_ready  = 1'b1;
        bus.rsp_ready  = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_smp_valid", bus.smp_valid, 1'b0);
        check("rst_smp_rsp_ready", bus.smp_rsp_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1'b1);

        // Full mask, lanes issued 0..3, one response pulse.
        rv0 = n_rv;
        send_req(4'b1111, 16'h1234, 32'h0, 32'h0, 1'b0);
        wait_rsp(1, "t1_rsp_done");
        @(negedge clk);
        check("t1_one_pulse", n_rv - rv0, 1);
        check("t1_issue_count", n_issue, 4);

        // Sparse mask.
        send_req(4'b1010, 16'h00A5, 32'h100, 32'h2000, 1'b1);
        wait_rsp(2, "t2_rsp_done");
        check("t2_issue_count", n_issue, 6);

        // Zero mask: response the cycle after accept, no issue.
        sv0 = n_sv;
        send_req(4'b0000, 16'hBEEF, 32'h55, 32'h66, 1'b0);
        #1;
        check("t3_rsp_next_cycle", bus.rsp_valid, 1'b1);
        check("t3_texels_zero", bus.rsp_texels, 128'h0);
        check("t3_tag", bus.rsp_tag, 16'hBEEF);
        wait_rsp(3, "t3_rsp_done");
        check("t3_no_smp_valid", n_sv - sv0, 0);

        // Issue backpressure toggling and response held for 5 cycles.
        st0           = n_stall;
        bus.rsp_ready = 1'b0;
        ready_mode    = 1'b1;
        send_req(4'b1111, 16'h7E57, 32'h1000, 32'h3000, 1'b1);
        w = 0;
        #1;
        while (!bus.rsp_valid && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("t4_rsp_seen", bus.rsp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("t4_rsp_hold_valid", bus.rsp_valid, 1'b1);
            check("t4_rsp_hold_tag", bus.rsp_tag, 16'h7E57);
            check("t4_rsp_hold_texels", bus.rsp_texels, exp_rsp[0].texels);
            check("t4_req_ready_low", bus.req_ready, 1'b0);
            @(negedge clk);
            #1;
        end
        ready_mode    = 1'b0;
        bus.smp_ready = 1'b1;
        bus.rsp_ready = 1'b1;
        wait_rsp(4, "t4_rsp_done");
        check("t4_stalls_seen", n_stall > st0, 1'b1);

        // Reset with two lanes outstanding.
        is0 = n_issue;
        send_req(4'b1111, 16'hDEAD, 32'h40, 32'h80, 1'b0);
        repeat (2) @(negedge clk);
        check("t5_two_issued", n_issue - is0, 2);
        #1;
        reset = 1'b1;
        pipe.delete();
        exp_iss.delete();
        exp_rsp.delete();
        in_flight         = 1'b0;
        bus.smp_rsp_valid = 1'b0;
        n_req   = 0;
        n_issue = 0;
        n_stall = 0;
        #2;
        check("t5_rst_req_ready", bus.req_ready, 1'b0);
        check("t5_rst_smp_valid", bus.smp_valid, 1'b0);
        check("t5_rst_smp_rsp_ready", bus.smp_rsp_ready, 1'b0);
        check("t5_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("t5_rst_smp_u", bus.smp_u, 32'h0);
        check("t5_rst_smp_v", bus.smp_v, 32'h0);
        check("t5_rst_smp_lod", bus.smp_lod, 4'h0);
        check("t5_rst_rsp_texels", bus.rsp_texels, 128'h0);
        check("t5_rst_rsp_tag", bus.rsp_tag, 16'h0);
`ifdef TEX_REQ_SEQUENCER_PERF_EN
        check("t5_rst_perf_reqs", perf_reqs, 32'h0);
        check("t5_rst_perf_lanes", perf_lanes, 32'h0);
        check("t5_rst_perf_stalls", perf_stalls, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_idle_req_ready", bus.req_ready, 1'b1);

        // Post-reset traffic: masks 1111 (two stall cycles), 0001, 0000.
        bus.smp_ready = 1'b0;
        send_req(4'b1111, 16'h0101, 32'h7, 32'h9, 1'b1);
        repeat (2) @(negedge clk);
        bus.smp_ready = 1'b1;
        wait_rsp(5, "t6_rsp1_done");
        send_req(4'b0001, 16'h0202, 32'hA0, 32'hB0, 1'b0);
        wait_rsp(6, "t6_rsp2_done");
        send_req(4'b0000, 16'h0303, 32'h0, 32'h0, 1'b0);
        wait_rsp(7, "t6_rsp3_done");
        check("t6_model_lanes", n_issue, 5);
        check("t6_model_stalls", n_stall, 2);
`ifdef TEX_REQ_SEQUENCER_PERF_EN
        check("t6_perf_reqs", perf_reqs, 32'd3);
        check("t6_perf_lanes", perf_lanes, 32'd5);
        check("t6_perf_stalls", perf_stalls, 32'd2);
        check("t6_perf_reqs_model", perf_reqs, 32'(n_req));
`endif
        check("t6_queues_empty", exp_iss.size() + exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
